// File: rtl/cmult_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmult_seq_pkg
//  Description : Shared types and defaults for the complex-multiplier stream
//                sequencer: complex sample type, FIFO entry type and default
//                configuration values.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef OVERALL_BITS
`define OVERALL_BITS 32
`endif

package cmult_seq_pkg;

    localparam int CMULT_LATENCY_DEF = 12;
    localparam int FIFO_DEPTH_DEF    = 16;
    localparam int TAG_BITS_DEF      = 8;
    localparam int DATA_BITS         = `OVERALL_BITS;

    typedef struct packed {
        logic signed [DATA_BITS-1:0] re;
        logic signed [DATA_BITS-1:0] im;
    } cplx_t;

    typedef struct packed {
        cplx_t                   prod;
        logic [TAG_BITS_DEF-1:0] tag;
    } seq_entry_t;

endpackage

`default_nettype wire

// File: rtl/cmult_seq_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : cmult_seq_fifo
//  Description : Synchronous FIFO with occupancy count. No fall-through: a
//                word written at one edge is readable from the next cycle.
//                The head word is presented combinationally from storage.
//  Ports       : clk, rst        clock / synchronous active-high reset
//                push, push_data write request and word
//                pop             read request (ignored while empty)
//                pop_data        word at the head of the queue
//                empty           no word stored
//                count           number of stored words (0..DEPTH)
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef OVERALL_BITS
`define OVERALL_BITS 32
`endif

module cmult_seq_fifo
    import cmult_seq_pkg::*;
#(
    parameter int  DEPTH = FIFO_DEPTH_DEF,
    parameter type T     = seq_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    output T                         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty    = (count_q == '0);
    assign w_full   = (count_q == (PTR_W+1)'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is only honoured when a pop frees the slot in
    // the same cycle.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~w_full | w_do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cmult_stream_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cmult_stream_sequencer
//  Description : Issues complex operand pairs to a fixed-latency, non-stalling
//                complex multiplier, tracks their tags through a delay line
//                and buffers products in a FIFO. Input acceptance is
//                credit-controlled so that no product is ever dropped.
//  Macro       : CMULT_SEQ_CHECK_EN - when defined, cm_done is compared with
//                the delay-line head every cycle outside the post-reset drain
//                window; any mismatch sets the sticky err_seq flag.
//                When undefined, err_seq is 0 and cm_done is unused.
//  Ports       : clk, rst                 clock / synchronous active-high reset
//                in_valid/in_ready        operand stream handshake
//                in_a_*, in_b_*, in_tag   operands and sideband tag
//                cm_start, cm_a_*, cm_b_* issue to the multiplier
//                cm_done, cm_res_*        multiplier completion and product
//                out_valid/out_ready      product stream handshake
//                out_real/imag, out_tag   product and its tag
//                err_seq                  sticky sequencing error
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef OVERALL_BITS
`define OVERALL_BITS 32
`endif

module cmult_stream_sequencer
    import cmult_seq_pkg::*;
#(
    parameter int CMULT_LATENCY = CMULT_LATENCY_DEF,
    parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF,
    parameter int TAG_BITS      = TAG_BITS_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [`OVERALL_BITS-1:0] in_a_real,
    input  logic [`OVERALL_BITS-1:0] in_a_imag,
    input  logic [`OVERALL_BITS-1:0] in_b_real,
    input  logic [`OVERALL_BITS-1:0] in_b_imag,
    input  logic [TAG_BITS-1:0]      in_tag,
    output logic                     cm_start,
    output logic [`OVERALL_BITS-1:0] cm_a_real,
    output logic [`OVERALL_BITS-1:0] cm_a_imag,
    output logic [`OVERALL_BITS-1:0] cm_b_real,
    output logic [`OVERALL_BITS-1:0] cm_b_imag,
    input  logic                     cm_done,
    input  logic [`OVERALL_BITS-1:0] cm_res_real,
    input  logic [`OVERALL_BITS-1:0] cm_res_imag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [`OVERALL_BITS-1:0] out_real,
    output logic [`OVERALL_BITS-1:0] out_imag,
    output logic [TAG_BITS-1:0]      out_tag,
    output logic                     err_seq
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int INF_W = $clog2(CMULT_LATENCY + 1);
    localparam int DRN_W = $clog2(CMULT_LATENCY + 2);
    localparam logic [DRN_W-1:0] DRAIN_CYCLES = DRN_W'(CMULT_LATENCY + 1);

    typedef struct packed {
        cplx_t               prod;
        logic [TAG_BITS-1:0] tag;
    } entry_t;

    // Issue stage
    logic                      issue_valid_q, issue_valid_d;
    cplx_t                     issue_a_q, issue_a_d;
    cplx_t                     issue_b_q, issue_b_d;
    logic [TAG_BITS-1:0]       issue_tag_q, issue_tag_d;

    // Tag delay line; slot CMULT_LATENCY-1 lines up with cm_done
    logic [CMULT_LATENCY-1:0]  dl_valid_q, dl_valid_d;
    logic [TAG_BITS-1:0]       dl_tag_q [CMULT_LATENCY];
    logic [TAG_BITS-1:0]       dl_tag_d [CMULT_LATENCY];

    logic [INF_W-1:0]          inflight_q, inflight_d;
    logic [DRN_W-1:0]          drain_cnt_q, drain_cnt_d;

    logic                      w_drain_active;
    logic                      w_accept;
    logic                      w_capture;
    logic                      w_pop;
    logic [TAG_BITS-1:0]       w_head_tag;
    logic [31:0]               w_occupancy;
    logic [CNT_W-1:0]          w_fifo_count;
    logic                      w_fifo_empty;
    entry_t                    w_push_entry;
    entry_t                    w_pop_entry;

    assign w_drain_active = (drain_cnt_q != '0);
    assign w_head_tag     = dl_tag_q[CMULT_LATENCY-1];
    // Stale multiplier results during the drain window are never captured.
    assign w_capture      = dl_valid_q[CMULT_LATENCY-1] & ~w_drain_active;

    // Every accepted operation owns one FIFO slot from acceptance until its
    // product is popped, so the FIFO can never overflow.
    assign w_occupancy = 32'(w_fifo_count) + 32'(inflight_q) + 32'(issue_valid_q);
    assign in_ready    = ~rst & ~w_drain_active & (w_occupancy < 32'(FIFO_DEPTH));
    assign w_accept    = in_valid & in_ready;

    assign cm_start  = issue_valid_q;
    assign cm_a_real = issue_a_q.re;
    assign cm_a_imag = issue_a_q.im;
    assign cm_b_real = issue_b_q.re;
    assign cm_b_imag = issue_b_q.im;

    always_comb begin
        issue_valid_d = w_accept;
        issue_a_d     = issue_a_q;
        issue_b_d     = issue_b_q;
        issue_tag_d   = issue_tag_q;
        if (w_accept) begin
            issue_a_d.re = in_a_real;
            issue_a_d.im = in_a_imag;
            issue_b_d.re = in_b_real;
            issue_b_d.im = in_b_imag;
            issue_tag_d  = in_tag;
        end

        dl_valid_d    = '0;
        dl_valid_d[0] = issue_valid_q;
        dl_tag_d[0]   = issue_tag_q;
        for (int i = 1; i < CMULT_LATENCY; i++) begin
            dl_valid_d[i] = dl_valid_q[i-1];
            dl_tag_d[i]   = dl_tag_q[i-1];
        end

        case ({issue_valid_q, w_capture})
            2'b10:   inflight_d = inflight_q + INF_W'(1);
            2'b01:   inflight_d = inflight_q - INF_W'(1);
            default: inflight_d = inflight_q;
        endcase

        drain_cnt_d = w_drain_active ? (drain_cnt_q - DRN_W'(1)) : drain_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid_q <= 1'b0;
            issue_a_q     <= '0;
            issue_b_q     <= '0;
            issue_tag_q   <= '0;
            dl_valid_q    <= '0;
            for (int i = 0; i < CMULT_LATENCY; i++) begin
                dl_tag_q[i] <= '0;
            end
            inflight_q    <= '0;
            drain_cnt_q   <= DRAIN_CYCLES;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_a_q     <= issue_a_d;
            issue_b_q     <= issue_b_d;
            issue_tag_q   <= issue_tag_d;
            dl_valid_q    <= dl_valid_d;
            for (int i = 0; i < CMULT_LATENCY; i++) begin
                dl_tag_q[i] <= dl_tag_d[i];
            end
            inflight_q    <= inflight_d;
            drain_cnt_q   <= drain_cnt_d;
        end
    end

    always_comb begin
        w_push_entry         = '0;
        w_push_entry.prod.re = cm_res_real;
        w_push_entry.prod.im = cm_res_imag;
        w_push_entry.tag     = w_head_tag;
    end

    assign w_pop = out_valid & out_ready;

    cmult_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_capture),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .pop_data  (w_pop_entry),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    assign out_valid = ~w_fifo_empty;
    assign out_real  = w_pop_entry.prod.re;
    assign out_imag  = w_pop_entry.prod.im;
    assign out_tag   = w_pop_entry.tag;

`ifdef CMULT_SEQ_CHECK_EN
    logic err_seq_q, err_seq_d;

    always_comb begin
        err_seq_d = err_seq_q | (~w_drain_active & (cm_done != dl_valid_q[CMULT_LATENCY-1]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_seq_q <= 1'b0;
        end else begin
            err_seq_q <= err_seq_d;
        end
    end

    assign err_seq = err_seq_q;
`else
    logic w_unused_cm_done;
    assign w_unused_cm_done = cm_done;
    assign err_seq          = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cmult_stream_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmult_stream_sequencer
//  Description : Self-checking bench for cmult_stream_sequencer with a
//                behavioural Q16.16 complex multiplier (no reset, fixed
//                latency) and a product scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef OVERALL_BITS
`define OVERALL_BITS 32
`endif

module tb_cmult_stream_sequencer;

    localparam int W     = `OVERALL_BITS;
    localparam int LAT   = 12;
    localparam int DEPTH = 16;
    localparam int TAGW  = 8;
    localparam int FRAC  = 16;

`ifdef CMULT_SEQ_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_a_real, in_a_imag, in_b_real, in_b_imag;
    logic [TAGW-1:0] in_tag;
    logic            cm_start;
    logic [W-1:0]    cm_a_real, cm_a_imag, cm_b_real, cm_b_imag;
    logic            cm_done;
    logic [W-1:0]    cm_res_real, cm_res_imag;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_real, out_imag;
    logic [TAGW-1:0] out_tag;
    logic            err_seq;
    logic            inj_done;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    cmult_stream_sequencer #(
        .CMULT_LATENCY (LAT),
        .FIFO_DEPTH    (DEPTH),
        .TAG_BITS      (TAGW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a_real   (in_a_real),
        .in_a_imag   (in_a_imag),
        .in_b_real   (in_b_real),
        .in_b_imag   (in_b_imag),
        .in_tag      (in_tag),
        .cm_start    (cm_start),
        .cm_a_real   (cm_a_real),
        .cm_a_imag   (cm_a_imag),
        .cm_b_real   (cm_b_real),
        .cm_b_imag   (cm_b_imag),
        .cm_done     (cm_done),
        .cm_res_real (cm_res_real),
        .cm_res_imag (cm_res_imag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_real    (out_real),
        .out_imag    (out_imag),
        .out_tag     (out_tag),
        .err_seq     (err_seq)
    );

    // ---------------- Q16.16 complex product ----------------
    function automatic logic [W-1:0] cmul_re(input logic [W-1:0] ar, ai, br, bi);
        longint p;
        p = longint'($signed(ar)) * longint'($signed(br)) - longint'($signed(ai)) * longint'($signed(bi));
        return W'(p >>> FRAC);
    endfunction

    function automatic logic [W-1:0] cmul_im(input logic [W-1:0] ar, ai, br, bi);
        longint p;
        p = longint'($signed(ar)) * longint'($signed(bi)) + longint'($signed(ai)) * longint'($signed(br));
        return W'(p >>> FRAC);
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [23:0] t;
        t = 24'($urandom);
        return {{(W-24){t[23]}}, t};
    endfunction

    // ---------------- multiplier model (no reset, non-stalling) ----------------
    logic [LAT-1:0] mdl_done_q = '0;
    logic [W-1:0]   mdl_re_q [LAT];
    logic [W-1:0]   mdl_im_q [LAT];

    always @(posedge clk) begin
        mdl_done_q  <= {mdl_done_q[LAT-2:0], cm_start};
        mdl_re_q[0] <= cmul_re(cm_a_real, cm_a_imag, cm_b_real, cm_b_imag);
        mdl_im_q[0] <= cmul_im(cm_a_real, cm_a_imag, cm_b_real, cm_b_imag);
        for (int i = 1; i < LAT; i++) begin
            mdl_re_q[i] <= mdl_re_q[i-1];
            mdl_im_q[i] <= mdl_im_q[i-1];
        end
    end

    assign cm_done     = mdl_done_q[LAT-1] | inj_done;
    assign cm_res_real = mdl_re_q[LAT-1];
    assign cm_res_imag = mdl_im_q[LAT-1];

    // ---------------- scoreboard and output monitor ----------------
    typedef struct {
        logic [W-1:0]    re;
        logic [W-1:0]    im;
        logic [TAGW-1:0] tag;
    } exp_t;

    exp_t         sb_q [$];
    exp_t         mon_e;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_re, prev_im;
    logic [TAGW-1:0] prev_tag;

    always @(negedge clk) begin
        if (prev_stall) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_real !== prev_re || out_imag !== prev_im || out_tag !== prev_tag) begin
                tests_failed++;
                $display("FAIL out_stable: got v=%0b %h %h tag=%h, required v=1 %h %h tag=%h",
                         out_valid, out_real, out_imag, out_tag, prev_re, prev_im, prev_tag);
            end
        end
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            tests_run++;
            if (sb_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_underflow: got product tag=%h, required no product", out_tag);
            end else begin
                mon_e = sb_q.pop_front();
                if (out_real !== mon_e.re || out_imag !== mon_e.im || out_tag !== mon_e.tag) begin
                    tests_failed++;
                    $display("FAIL product: got %h %h tag=%h, required %h %h tag=%h",
                             out_real, out_imag, out_tag, mon_e.re, mon_e.im, mon_e.tag);
                end
            end
        end
        prev_stall = (rst === 1'b0) && (out_valid === 1'b1) && (out_ready === 1'b0);
        prev_re    = out_real;
        prev_im    = out_imag;
        prev_tag   = out_tag;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [W-1:0] ar, ai, br, bi, input logic [TAGW-1:0] tag);
        in_valid  = 1'b1;
        in_a_real = ar;
        in_a_imag = ai;
        in_b_real = br;
        in_b_imag = bi;
        in_tag    = tag;
    endtask

    // Holds the operation until accepted; returns with in_valid still high,
    // one time unit after the accepting edge.
    task automatic send_op(input logic [W-1:0] ar, ai, br, bi, input logic [TAGW-1:0] tag,
                           output int stalls);
        exp_t e;
        stalls = 0;
        drive_op(ar, ai, br, bi, tag);
        @(negedge clk);
        while (in_ready !== 1'b1 && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        if (in_ready === 1'b1) begin
            e.re  = cmul_re(ar, ai, br, bi);
            e.im  = cmul_im(ar, ai, br, bi);
            e.tag = tag;
            sb_q.push_back(e);
        end
        wait_pos();
    endtask

    task automatic wait_sb_empty(input string name);
        int c = 0;
        while (sb_q.size() != 0 && c < 300) begin
            wait_pos();
            c++;
        end
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_drain: got %0d products outstanding, required 0", name, sb_q.size());
        end
    endtask

    task automatic check_drain_window(input string name);
        int n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        tests_run++;
        if (n != LAT + 1) begin
            tests_failed++;
            $display("FAIL %s_drain_window: got %0d cycles of in_ready=0, required %0d", name, n, LAT + 1);
        end
        wait_pos();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) wait_pos();
        @(negedge clk);
        tests_run += 5;
        if (cm_start !== 1'b0) begin tests_failed++; $display("FAIL rst_cm_start: got %b, required 0", cm_start); end
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        if (err_seq !== 1'b0) begin tests_failed++; $display("FAIL rst_err_seq: got %b, required 0", err_seq); end
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
        if ({cm_a_real, cm_a_imag, cm_b_real, cm_b_imag} !== '0) begin
            tests_failed++;
            $display("FAIL rst_cm_operands: got %h %h %h %h, required 0", cm_a_real, cm_a_imag, cm_b_real, cm_b_imag);
        end
        wait_pos();
        rst = 1'b0;
        check_drain_window("reset");
    endtask

    task automatic test_single();
        int s;
        int n;
        out_ready = 1'b1;
        send_op(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 8'h5A, s);
        in_valid = 1'b0;
        @(negedge clk);
        tests_run += 3;
        if (s != 0) begin tests_failed++; $display("FAIL single_accept: got %0d stall cycles, required 0", s); end
        if (cm_start !== 1'b1) begin tests_failed++; $display("FAIL single_cm_start: got %b, required 1", cm_start); end
        if (cm_a_real !== 32'h0001_0000 || cm_b_imag !== 32'h0004_0000) begin
            tests_failed++;
            $display("FAIL single_cm_ops: got a_re=%h b_im=%h, required 00010000 00040000", cm_a_real, cm_b_imag);
        end
        @(negedge clk);
        n = 2;
        tests_run++;
        if (cm_start !== 1'b0) begin tests_failed++; $display("FAIL single_start_pulse: got %b, required 0", cm_start); end
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        tests_run += 2;
        if (n != LAT + 2) begin tests_failed++; $display("FAIL single_latency: got %0d cycles, required %0d", n, LAT + 2); end
        if (out_real !== 32'hFFFB_0000 || out_imag !== 32'h000A_0000 || out_tag !== 8'h5A) begin
            tests_failed++;
            $display("FAIL single_value: got %h %h tag=%h, required fffb0000 000a0000 tag=5a", out_real, out_imag, out_tag);
        end
        wait_pos();
        wait_sb_empty("single");
    endtask

    task automatic test_stream();
        int total_stall = 0;
        out_ready = 1'b1;
        fork
            begin
                int s;
                for (int i = 0; i < 32; i++) begin
                    send_op(rnd(), rnd(), rnd(), rnd(), TAGW'(i), s);
                    total_stall += s;
                end
                in_valid = 1'b0;
            end
            begin
                int n = 0;
                @(negedge clk);
                while (out_valid !== 1'b1 && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                for (int k = 0; k < 32; k++) begin
                    tests_run++;
                    if (out_valid !== 1'b1 || out_tag !== TAGW'(k)) begin
                        tests_failed++;
                        $display("FAIL stream_order: got v=%b tag=%h, required v=1 tag=%h", out_valid, out_tag, TAGW'(k));
                    end
                    @(negedge clk);
                end
            end
        join
        tests_run++;
        if (total_stall != 0) begin tests_failed++; $display("FAIL stream_in_ready: got %0d stall cycles, required 0", total_stall); end
        wait_pos();
        wait_sb_empty("stream");
    endtask

    task automatic test_backpressure();
        int n_acc = 0;
        int n;
        exp_t e;
        logic [W-1:0] ar, ai, br, bi;
        out_ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            ar = rnd(); ai = rnd(); br = rnd(); bi = rnd();
            drive_op(ar, ai, br, bi, TAGW'(100 + n_acc));
            @(negedge clk);
            if (in_ready === 1'b1) begin
                e.re  = cmul_re(ar, ai, br, bi);
                e.im  = cmul_im(ar, ai, br, bi);
                e.tag = TAGW'(100 + n_acc);
                sb_q.push_back(e);
                n_acc++;
            end
            wait_pos();
        end
        in_valid = 1'b0;
        @(negedge clk);
        tests_run += 2;
        if (n_acc != DEPTH) begin tests_failed++; $display("FAIL bp_accepted: got %0d, required %0d", n_acc, DEPTH); end
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready_full: got %b, required 0", in_ready); end
        wait_pos();
        out_ready = 1'b1;
        n = 1;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n != 2) begin tests_failed++; $display("FAIL bp_credit_return: got in_ready at cycle %0d, required 2", n); end
        wait_pos();
        wait_sb_empty("bp");
    endtask

    task automatic test_full_push_pop();
        int s;
        int total_stall = 0;
        int n = 0;
        int sz;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            send_op(rnd(), rnd(), rnd(), rnd(), TAGW'(200 + i), s);
            total_stall += s;
        end
        in_valid = 1'b0;
        while (dut.w_fifo_count !== 5'd15 && n < 50) begin
            wait_pos();
            n++;
        end
        tests_run += 2;
        if (total_stall != 0) begin tests_failed++; $display("FAIL full_fill: got %0d stall cycles, required 0", total_stall); end
        if (dut.w_fifo_count !== 5'd15) begin tests_failed++; $display("FAIL full_reach15: got count %0d, required 15", dut.w_fifo_count); end
        sz = sb_q.size();
        out_ready = 1'b1;
        wait_pos();
        out_ready = 1'b0;
        tests_run += 2;
        if (dut.w_fifo_count !== 5'd15) begin tests_failed++; $display("FAIL full_pushpop_count: got %0d, required 15", dut.w_fifo_count); end
        if (sb_q.size() != sz - 1) begin tests_failed++; $display("FAIL full_pushpop_pop: got %0d outstanding, required %0d", sb_q.size(), sz - 1); end
        wait_pos();
        out_ready = 1'b1;
        wait_sb_empty("full");
        wait_pos();
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL full_no_dup: got out_valid=%b, required 0", out_valid); end
        wait_pos();
    endtask

    task automatic test_spurious_done();
        out_ready = 1'b1;
        repeat (3) wait_pos();
        @(negedge clk);
        tests_run++;
        if (err_seq !== 1'b0) begin tests_failed++; $display("FAIL spur_pre: got err_seq=%b, required 0", err_seq); end
        wait_pos();
        inj_done = 1'b1;
        wait_pos();
        inj_done = 1'b0;
        @(negedge clk);
        tests_run++;
        if (err_seq !== EXP_ERR) begin tests_failed++; $display("FAIL spur_set: got err_seq=%b, required %b", err_seq, EXP_ERR); end
        repeat (5) wait_pos();
        @(negedge clk);
        tests_run++;
        if (err_seq !== EXP_ERR) begin tests_failed++; $display("FAIL spur_hold: got err_seq=%b, required %b", err_seq, EXP_ERR); end
        wait_pos();
        rst = 1'b1;
        wait_pos();
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (err_seq !== 1'b0) begin tests_failed++; $display("FAIL spur_clear: got err_seq=%b, required 0", err_seq); end
        repeat (LAT + 2) wait_pos();
    endtask

    task automatic test_reset_midflight();
        int s;
        int total_stall = 0;
        int zeros = 0;
        logic got_ready = 1'b0;
        logic saw_valid = 1'b0;
        logic saw_err = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_op(rnd(), rnd(), rnd(), rnd(), TAGW'(50 + i), s);
            total_stall += s;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        sb_q.delete();
        wait_pos();
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (in_ready !== 1'b1 && !got_ready) zeros++;
            else got_ready = 1'b1;
            if (out_valid !== 1'b0) saw_valid = 1'b1;
            if (err_seq !== 1'b0) saw_err = 1'b1;
        end
        tests_run += 4;
        if (total_stall != 0) begin tests_failed++; $display("FAIL mid_issue: got %0d stall cycles, required 0", total_stall); end
        if (zeros != LAT + 1) begin tests_failed++; $display("FAIL mid_drain_window: got %0d cycles, required %0d", zeros, LAT + 1); end
        if (saw_valid) begin tests_failed++; $display("FAIL mid_out_valid: got out_valid=1, required 0"); end
        if (saw_err) begin tests_failed++; $display("FAIL mid_err_seq: got err_seq=1, required 0"); end
        wait_pos();
        send_op(32'h0000_8000, 32'hFFFF_0000, 32'h0002_0000, 32'h0000_4000, 8'hC3, s);
        in_valid = 1'b0;
        tests_run++;
        if (s != 0) begin tests_failed++; $display("FAIL mid_recover_accept: got %0d stall cycles, required 0", s); end
        wait_sb_empty("mid_recover");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a_real = '0;
        in_a_imag = '0;
        in_b_real = '0;
        in_b_imag = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        inj_done  = 1'b0;

        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_full_push_pop();
        test_spurious_done();
        test_reset_midflight();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
